// File: rtl/ct_mod_calendar.sv
// ct_mod_calendar: day/month/year calendar counter with Gregorian leap years, validated load and end-of-month/year flags
module ct_mod_calendar #(
  parameter int X = 31,
  parameter int Y = 30,
  parameter int Z = 28,
  parameter int YEAR_W = 7,
  parameter int BASE_YEAR = 2000,
  parameter bit LEAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [4:0]        ld_day,
  input  logic [3:0]        ld_month,
  input  logic [YEAR_W-1:0] ld_year,
  output logic [6:0]        day_out,
  output logic [3:0]        month_out,
  output logic [YEAR_W-1:0] year_out,
  output logic              leap,
  output logic              z,
  output logic              z_year,
  output logic              load_err
);
  logic [6:0] day;
  logic [3:0] month;
  logic [YEAR_W-1:0] year;
  logic [6:0] dim_cur;
  logic ld_ok;
  function automatic logic is_leap(input logic [YEAR_W-1:0] yr);
    int ya;
    ya = BASE_YEAR + int'(yr);
    return LEAP_EN && (ya % 4 == 0) && ((ya % 100 != 0) || (ya % 400 == 0));
  endfunction
  function automatic logic [6:0] dim(input logic [3:0] m, input logic [YEAR_W-1:0] yr);
    return (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 7'(Y) :
           (m == 4'd2) ? 7'(Z) + {6'd0, is_leap(yr)} : 7'(X);
  endfunction
  always_comb begin
    dim_cur = dim(month, year);
    ld_ok = ld_month >= 4'd1 && ld_month <= 4'd12 && ld_day != 5'd0 &&
            {2'b00, ld_day} <= dim(ld_month, ld_year);
    leap = is_leap(year);
    z = day == dim_cur;
    z_year = z && month == 4'd12;
  end
  assign day_out = day;
  assign month_out = month;
  assign year_out = year;
  always_ff @(posedge clk) begin
    if (rst) begin
      day <= 7'd1;
      month <= 4'd1;
      year <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= load && !ld_ok;
      if (load) begin
        if (ld_ok) begin
          day <= {2'b00, ld_day};
          month <= ld_month;
          year <= ld_year;
        end
      end else if (en) begin
        day <= (day < dim_cur) ? day + 7'd1 : 7'd1;
        if (day >= dim_cur) begin
          month <= (month < 4'd12) ? month + 4'd1 : 4'd1;
          if (month >= 4'd12) year <= year + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/ct_mod_calendar.md
# ct_mod_calendar

Parametrised day/month/year calendar counter for the clock/date datapath. It advances one day per `en` tick and handles variable month lengths and Gregorian leap years. It also supports a validated parallel load for setting the date, and flags end-of-month and end-of-year for downstream display and alarm logic. It supersedes the standalone per-month date counter: month and year are now tracked internally rather than supplied from outside.

## Interface
- `X`, 31, length of long months (1,3,5,7,8,10,12)
- `Y`, 30, length of short months (4,6,9,11)
- `Z`, 28, length of February in a common year; leap February is `Z`+1
- `YEAR_W`, 7, width of year offset counter
- `BASE_YEAR`, 2000, calendar year represented by `year_out` = 0
- `LEAP_EN`, 1, 1 = Gregorian leap rule applied; 0 = February always `Z`

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  day-advance tick; one day per cycle while high
- `load`  in  1  request to load `ld_day`/`ld_month`/`ld_year`
- `ld_day`  in  5  day to load (1-based)
- `ld_month`  in  4  month to load (1..12)
- `ld_year`  in  `YEAR_W`  year offset to load
- `day_out`  out  7  current day, 1..days-in-month, zero-extended
- `month_out`  out  4  current month, 1..12
- `year_out`  out  `YEAR_W`  current year offset from `BASE_YEAR`
- `leap`  out  1  current year is leap (0 when `LEAP_EN`=0)
- `z`  out  1  `day_out` equals last day of current month
- `z_year`  out  1  `z` and `month_out` = 12
- `load_err`  out  1  one-cycle pulse: previous-cycle load rejected

## Operation
- State: registered `day`, `month`, `year`, `load_err`. All other outputs are combinational from registered state.
- Reset (`rst`=1 at edge): day=1, month=1, year=0, load_err=0. Reset has the highest priority and overrides `load` and `en`.
- Leap rule: with Y_abs = `BASE_YEAR` + year, computed at 32-bit integer width, leap = `LEAP_EN` and (Y_abs%4==0) and ((Y_abs%100!=0) or (Y_abs%400==0)).
- Days-in-month dim(m,y) is `X` for months 1,3,5,7,8,10,12 and `Y` for months 4,6,9,11. February is `Z`+leap. Any other month value gives dim = `X`; this is unreachable in normal operation.
- Priority below reset is `load`, then `en`, then hold.
- Load: accepted iff 1 ≤ `ld_month` ≤ 12 and 1 ≤ `ld_day` ≤ dim(`ld_month`, `ld_year`). Leap is evaluated on `ld_year`, not on the current year.
  - Accepted: the state takes the load values and load_err=0.
  - Rejected: the state holds and load_err=1 for exactly the next cycle.
  - `en` in the same cycle as `load` is ignored, whether the load is accepted or rejected.
- Advance (`en`=1, no load):
  - If day < dim: day+1.
  - Else if month < 12: day=1, month+1.
  - Else: day=1, month=1, year+1 mod 2^`YEAR_W`. Wrap from all-ones to 0 is silent.
- Hold: with no `rst`, `load` or `en`, all state holds and load_err=0.
- load_err clears on any cycle without a rejected load.

## Timing
- All updates take effect one cycle after the sampling edge. No multi-cycle operations and no internal pipeline.
- `z`, `z_year` and `leap` reflect the registered state in the same cycle, with zero added latency.
- `en` held high for N cycles advances exactly N days. Back-to-back month and year rollovers need no stall.
- After reset, outputs read 1/1/0, `leap`=1 for `BASE_YEAR`=2000, `z`=0, `z_year`=0, `load_err`=0.
- A reset asserted mid-operation, including in the same cycle as `load` or `en`, wins, and the next cycle shows the reset values.
- `load_err` is high for one cycle per rejected load. Consecutive rejected loads keep it high.

## Test plan
- Reset, then `en` for 31 cycles: day 1→31 with `z`=1 at 31; next tick gives day=1, month=2, `z`=0.
- Load 28/2/year 1 (2001), one `en` → 1/3/1. Load 28/2/year 0 (2000), one `en` → 29/2/0 with `z`=1, next `en` → 1/3/0.
- `BASE_YEAR`=1900: load 28/2/0, `en` → 1/3/0 (1900 not leap). `LEAP_EN`=0, `BASE_YEAR`=2000: 28/2/0 + `en` → 1/3/0, `leap`=0.
- Load 31/12/127 with `YEAR_W`=7: `z_year`=1; `en` → 1/1/0, `z_year`=0.
- Load 30/2/1, then load 5/13/0, then load 0/4/0: each rejected, state unchanged, `load_err`=1 on the cycle after each. Load 31/4/0 also rejected.
- Same-cycle `load`(15/6/3)+`en` → 15/6/3. `rst`+`load` → 1/1/0. `rst` asserted mid-count at 17/8/5 → 1/1/0 the next cycle.
